// File: rtl/uart_rx_fifo_if.sv
// Push/pop handshake and status bundle between the UART receiver side,
// the FIFO and the command/program-loader side.
interface uart_rx_fifo_if #(
  parameter int B      = 8,
  parameter int ADDR_W = 4
);
  logic              i_wr;
  logic [B-1:0]      i_w_data;
  logic              i_rd;
  logic              i_clr_err;
  logic [B-1:0]      o_r_data;
  logic              o_empty;
  logic              o_full;
  logic              o_almost_full;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              o_underflow;

  // Client side: pushes bytes, pops them, observes status.
  modport master (
    output i_wr, i_w_data, i_rd, i_clr_err,
    input  o_r_data, o_empty, o_full, o_almost_full, o_count,
           o_overflow, o_underflow
  );

  // FIFO side.
  modport slave (
    input  i_wr, i_w_data, i_rd, i_clr_err,
    output o_r_data, o_empty, o_full, o_almost_full, o_count,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the
// command/program-loader interface. Head entry is read combinationally,
// flags are decoded from the registered occupancy so they move with it.
module uart_rx_fifo #(
  parameter int B        = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 2**ADDR_W - 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  uart_rx_fifo_if.slave    bus
);
  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [B-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              empty, full;
  logic              do_wr, do_rd;
  logic              ovf_evt, udf_evt;
  logic              ovf, udf;

  // Flag decode and effective push/pop; a pop frees the slot a full push needs.
  always_comb begin
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    do_wr   = bus.i_wr & (~full | bus.i_rd);
    do_rd   = bus.i_rd & ~empty;
    ovf_evt = bus.i_wr & full & ~bus.i_rd;
    udf_evt = bus.i_rd & empty;
  end

  // Storage array is not reset; contents only matter once counted.
  always_ff @(posedge i_clock) begin
    if (do_wr) mem[wr_ptr] <= bus.i_w_data;
  end

  // Pointers, occupancy and sticky error flags (new event beats clear).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf <= ovf_evt | (ovf & ~bus.i_clr_err);
      udf <= udf_evt | (udf & ~bus.i_clr_err);
    end
  end

  assign bus.o_r_data      = mem[rd_ptr];
  assign bus.o_empty       = empty;
  assign bus.o_full        = full;
  assign bus.o_almost_full = (count >= AF_C);
  assign bus.o_count       = count;
  assign bus.o_overflow    = ovf;
  assign bus.o_underflow   = udf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH=4, AF_LEVEL=2.
module tb_uart_rx_fifo;
  logic i_clock;
  logic i_reset;
  int   n_chk;
  int   n_fail;

  uart_rx_fifo_if #(.B(8), .ADDR_W(2)) bus ();

  uart_rx_fifo #(.B(8), .ADDR_W(2), .AF_LEVEL(2)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Advance one edge and settle 1ns past it.
  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    bus.i_wr = 1'b0; bus.i_rd = 1'b0; bus.i_clr_err = 1'b0; bus.i_w_data = 8'h00;
    tick; tick;
    n_chk++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== 3'd0 || bus.o_full !== 1'b0 ||
        bus.o_almost_full !== 1'b0 || bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: empty=%b count=%0d full=%b af=%b ovf=%b udf=%b, required 1 0 0 0 0 0",
               bus.o_empty, bus.o_count, bus.o_full, bus.o_almost_full, bus.o_overflow, bus.o_underflow);
    end
    i_reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [7:0] exp_q [3];
    exp_q = '{8'hFE, 8'h05, 8'h00};
    bus.i_wr = 1'b1; bus.i_w_data = 8'hFF;
    tick;
    n_chk++;
    if (bus.o_empty !== 1'b0 || bus.o_r_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL first_push: empty=%b data=%h, required 0 ff", bus.o_empty, bus.o_r_data);
    end
    bus.i_w_data = 8'hFE; tick;
    bus.i_w_data = 8'h05; tick;
    bus.i_wr = 1'b0;
    n_chk++;
    if (bus.o_count !== 3'd3) begin
      n_fail++;
      $display("FAIL count3: count=%0d, required 3", bus.o_count);
    end
    bus.i_rd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_chk++;
      if (bus.o_r_data !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_pop%0d: data=%h, required %h", i, bus.o_r_data, exp_q[i]);
      end
    end
    tick;
    bus.i_rd = 1'b0;
    n_chk++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_drained: empty=%b count=%0d, required 1 0", bus.o_empty, bus.o_count);
    end
  endtask

  task automatic test_full_overflow;
    logic [2:0] cnt;
    logic       af_exp;
    for (int i = 1; i <= 4; i++) begin
      bus.i_wr = 1'b1; bus.i_w_data = 8'(i);
      tick;
      cnt = 3'(i);
      af_exp = (i >= 2);
      n_chk++;
      if (bus.o_count !== cnt || bus.o_almost_full !== af_exp || bus.o_full !== (i == 4)) begin
        n_fail++;
        $display("FAIL fill%0d: count=%0d af=%b full=%b, required %0d %b %b",
                 i, bus.o_count, bus.o_almost_full, bus.o_full, cnt, af_exp, (i == 4));
      end
    end
    bus.i_w_data = 8'hAA;
    tick;
    bus.i_wr = 1'b0;
    n_chk++;
    if (bus.o_overflow !== 1'b1 || bus.o_count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b count=%0d, required 1 4", bus.o_overflow, bus.o_count);
    end
    bus.i_rd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (bus.o_r_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_ovf%0d: data=%h, required %h", i, bus.o_r_data, 8'(i));
      end
      tick;
    end
    bus.i_rd = 1'b0;
    n_chk++;
    if (bus.o_empty !== 1'b1 || bus.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_ovf_end: empty=%b ovf=%b, required 1 1", bus.o_empty, bus.o_overflow);
    end
    bus.i_clr_err = 1'b1; tick; bus.i_clr_err = 1'b0;
    n_chk++;
    if (bus.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clr: ovf=%b, required 0", bus.o_overflow);
    end
  endtask

  task automatic test_full_rw;
    logic [7:0] exp_q [4];
    exp_q = '{8'h32, 8'h33, 8'h34, 8'h55};
    for (int i = 1; i <= 4; i++) begin
      bus.i_wr = 1'b1; bus.i_w_data = 8'h30 + 8'(i);
      tick;
    end
    bus.i_w_data = 8'h55; bus.i_rd = 1'b1;
    tick;
    bus.i_wr = 1'b0;
    n_chk++;
    if (bus.o_count !== 3'd4 || bus.o_full !== 1'b1 || bus.o_r_data !== 8'h32 || bus.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rw: count=%0d full=%b data=%h ovf=%b, required 4 1 32 0",
               bus.o_count, bus.o_full, bus.o_r_data, bus.o_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (bus.o_r_data !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_rw_drain%0d: data=%h, required %h", i, bus.o_r_data, exp_q[i]);
      end
      tick;
    end
    bus.i_rd = 1'b0;
    n_chk++;
    if (bus.o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw_empty: empty=%b, required 1", bus.o_empty);
    end
  endtask

  task automatic test_underflow;
    bus.i_rd = 1'b1; tick; bus.i_rd = 1'b0;
    n_chk++;
    if (bus.o_underflow !== 1'b1 || bus.o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow_set: udf=%b count=%0d, required 1 0", bus.o_underflow, bus.o_count);
    end
    bus.i_clr_err = 1'b1; tick; bus.i_clr_err = 1'b0;
    n_chk++;
    if (bus.o_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clr: udf=%b, required 0", bus.o_underflow);
    end
    // new event in the same cycle as clear must win
    bus.i_rd = 1'b1; bus.i_clr_err = 1'b1; tick;
    bus.i_rd = 1'b0; bus.i_clr_err = 1'b0;
    n_chk++;
    if (bus.o_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clr: udf=%b, required 1", bus.o_underflow);
    end
    bus.i_clr_err = 1'b1; tick; bus.i_clr_err = 1'b0;
  endtask

  task automatic test_no_bypass;
    bus.i_wr = 1'b1; bus.i_rd = 1'b1; bus.i_w_data = 8'h66;
    tick;
    bus.i_wr = 1'b0; bus.i_rd = 1'b0;
    n_chk++;
    if (bus.o_count !== 3'd1 || bus.o_r_data !== 8'h66 || bus.o_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL no_bypass: count=%0d data=%h udf=%b, required 1 66 1",
               bus.o_count, bus.o_r_data, bus.o_underflow);
    end
    bus.i_rd = 1'b1; bus.i_clr_err = 1'b1; tick;
    bus.i_rd = 1'b0; bus.i_clr_err = 1'b0;
  endtask

  task automatic test_wrap;
    bus.i_wr = 1'b1; bus.i_w_data = 8'h10;
    tick;
    bus.i_rd = 1'b1;
    for (int i = 1; i < 10; i++) begin
      n_chk++;
      if (bus.o_r_data !== 8'h10 + 8'(i - 1) || bus.o_count !== 3'd1) begin
        n_fail++;
        $display("FAIL wrap%0d: data=%h count=%0d, required %h 1",
                 i, bus.o_r_data, bus.o_count, 8'h10 + 8'(i - 1));
      end
      bus.i_w_data = 8'h10 + 8'(i);
      tick;
    end
    bus.i_wr = 1'b0;
    n_chk++;
    if (bus.o_r_data !== 8'h19 || bus.o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_last: data=%h count=%0d, required 19 1", bus.o_r_data, bus.o_count);
    end
    tick;
    bus.i_rd = 1'b0;
    n_chk++;
    if (bus.o_empty !== 1'b1 || bus.o_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: empty=%b udf=%b, required 1 0", bus.o_empty, bus.o_underflow);
    end
  endtask

  task automatic test_async_reset;
    bus.i_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_w_data = 8'hC0 + 8'(i);
      tick;
    end
    bus.i_wr = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    n_chk++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: empty=%b count=%0d, required 1 0", bus.o_empty, bus.o_count);
    end
    #1 i_reset = 1'b0;
    tick;
    bus.i_wr = 1'b1; bus.i_w_data = 8'h77;
    tick;
    bus.i_wr = 1'b0;
    n_chk++;
    if (bus.o_r_data !== 8'h77 || bus.o_empty !== 1'b0 || bus.o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL post_reset_push: data=%h empty=%b count=%0d, required 77 0 1",
               bus.o_r_data, bus.o_empty, bus.o_count);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset;
    test_basic;
    test_full_overflow;
    test_full_rw;
    test_underflow;
    test_no_bypass;
    test_wrap;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
